score_bcd_scheduler: RTL
========================

# score_bcd_scheduler

Sequential binary-to-BCD conversion engine shared by up to three gameplay requesters: live score, high score and note-streak counter. Requesters post one-cycle strobes. The block latches each request, picks one by round-robin, and runs a one-bit-per-cycle double-dabble (add-3/shift) conversion. It returns the packed BCD result with a done pulse and requester tag, so the 7-segment/VGA digit renderers receive settled, registered digits.

## Interface
Parameters:
- BIN_W, 20, binary input width.
- DIGITS, 7, BCD digits produced. Must satisfy 10^DIGITS > 2^BIN_W − 1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req  in  3  per-requester strobes; bit i = requester i.
- bin0, bin1, bin2  in  BIN_W each  binary values; binN sampled only in the grant cycle for requester N.
- busy  out  1  high whenever state ≠ IDLE.
- grant  out  3  one-hot, one-cycle pulse when a conversion starts.
- done  out  1  one-cycle pulse; bcd_out and done_id are valid from this cycle.
- done_id  out  2  index of the requester whose result is on bcd_out.
- bcd_out  out  4*DIGITS  packed BCD, most significant digit in the top nibble; held until the next done.

## Operation
- pending[2:0] register: bit i is set by req[i]=1 and cleared by grant of i.
  - Same-cycle set and clear of the same bit resolves to clear. The value sampled at grant is the most recent one, so the requests merge.
- last_id register, reset value 2. After reset, requester 0 has top priority.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If pending (including req this cycle) is non-zero, choose the first set index scanning last_id+1, last_id+2, last_id+3 (mod 3).
  - On that choice: latch bin of the chosen requester into shift_bin, clear the BCD accumulator, set bit counter = BIN_W−1, pulse grant, update last_id, go to SHIFT.
- SHIFT (exactly BIN_W cycles):
  - Per cycle, first add 3 to every 4-bit accumulator digit that is ≥5.
  - Then shift the whole accumulator left 1, inserting shift_bin[counter] at bit 0, and decrement counter.
  - When counter = 0 completes, go to DONE.
- DONE:
  - Register the accumulator into bcd_out, set done_id, pulse done, go to IDLE.
- Arithmetic: every digit stays ≤9 after shifting. No carry leaves the top digit, given the DIGITS constraint. No overflow output.
- req while busy: only sets pending. The current conversion is not affected.
- Reset mid-conversion: the conversion is abandoned and no done is issued. pending is cleared.

## Timing
- Reset values:
  - grant=0, done=0, busy=0, done_id=0, bcd_out=0.
  - pending=0, last_id=2, state=IDLE.
- Outputs are registered. A req seen at edge E0 with the block in IDLE gives grant high in the cycle after E0.
- busy rises together with grant and falls the cycle after done.
- done is high BIN_W+1 cycles after grant (21 for defaults).
- Earliest next grant is the cycle after done. Back-to-back throughput is one conversion per BIN_W+2 cycles (22).
- Pending requests are never dropped. A continuously asserted req[i] is served at most once per round-robin turn.

## Test plan
- Single conversion: bin0=12345, req=3'b001 for 1 cycle → grant=001 next cycle; 21 cycles later done=1, done_id=0, bcd_out=28'h0012345.
- Width extremes: bin1=1048575 → bcd_out=28'h1048575. bin1=0 → 28'h0000000. bin1=999999 → 28'h0999999.
- Simultaneous requests: req=3'b111 in one cycle after reset → grants in order 0, 1, 2, spaced 22 cycles apart, with done_id 0, 1, 2 and each bcd_out matching its bin.
- Fairness: req[0] and req[2] held high continuously → grant sequence alternates 0, 2, 0, 2. Requester 1 never granted.
- Re-request while busy: req[0] pulse, then req[0] pulse again at grant+5 with a new bin0 → second conversion starts the cycle after the first done and uses bin0 as held at that grant.
- Reset mid-operation: assert reset at grant+10 → all outputs 0 immediately and no done. After release, a fresh req[2] gives grant=100 and a correct result.

Source files
------------

// File: rtl/score_bcd_scheduler.sv
// Shared binary-to-BCD converter: latches requests from three requesters, grants one
// by round-robin, and runs a one-bit-per-cycle double-dabble conversion.
module score_bcd_scheduler #(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            req,
  input  logic [BIN_W-1:0]      bin0,
  input  logic [BIN_W-1:0]      bin1,
  input  logic [BIN_W-1:0]      bin2,
  output logic                  busy,
  output logic [2:0]            grant,
  output logic                  done,
  output logic [1:0]            done_id,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int CW = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int AW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        pending_q, pending_d;
  logic [1:0]        last_id_q, last_id_d;
  logic [1:0]        cur_id_q, cur_id_d;
  logic [BIN_W-1:0]  shift_bin_q, shift_bin_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [2:0]        grant_q, grant_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [1:0]        done_id_q, done_id_d;
  logic [AW-1:0]     bcd_q, bcd_d;

  logic [2:0]        pendAll;
  logic [1:0]        pickId;
  logic [2:0]        idxSum;
  logic [AW-1:0]     adjAcc;
  logic [AW-1:0]     shiftedAcc;
  logic [BIN_W-1:0]  pickBin;

  assign pendAll = pending_q | req;

  // Scan from farthest to nearest so the nearest set index after last_id wins.
  always_comb begin
    pickId = 2'd0;
    idxSum = 3'd0;
    for (int k = 3; k >= 1; k--) begin
      idxSum = {1'b0, last_id_q} + 3'(k);
      if (idxSum >= 3'd3) idxSum = idxSum - 3'd3;
      if (pendAll[idxSum[1:0]]) pickId = idxSum[1:0];
    end
  end

  always_comb begin
    case (pickId)
      2'd0:    pickBin = bin0;
      2'd1:    pickBin = bin1;
      default: pickBin = bin2;
    endcase
  end

  always_comb begin
    adjAcc = acc_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc_q[4*d +: 4] >= 4'd5) adjAcc[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
    end
  end

  assign shiftedAcc = {adjAcc[AW-2:0], shift_bin_q[cnt_q]};

  always_comb begin
    state_d     = state_q;
    pending_d   = pendAll;
    last_id_d   = last_id_q;
    cur_id_d    = cur_id_q;
    shift_bin_d = shift_bin_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    grant_d     = 3'b000;
    done_d      = 1'b0;
    done_id_d   = done_id_q;
    bcd_d       = bcd_q;
    case (state_q)
      IDLE: begin
        if (|pendAll) begin
          grant_d[pickId]   = 1'b1;
          pending_d[pickId] = 1'b0;
          last_id_d         = pickId;
          cur_id_d          = pickId;
          shift_bin_d       = pickBin;
          acc_d             = '0;
          cnt_d             = CW'(BIN_W - 1);
          state_d           = SHIFT;
        end
      end
      SHIFT: begin
        acc_d = shiftedAcc;
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE: begin
        bcd_d     = acc_q;
        done_id_d = cur_id_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // busy stays up through the done cycle and drops on the following one.
    busy_d = (state_d != IDLE) || done_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pending_q   <= 3'b000;
      last_id_q   <= 2'd2;
      cur_id_q    <= 2'd0;
      shift_bin_q <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      grant_q     <= 3'b000;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_id_q   <= 2'd0;
      bcd_q       <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      last_id_q   <= last_id_d;
      cur_id_q    <= cur_id_d;
      shift_bin_q <= shift_bin_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      done_id_q   <= done_id_d;
      bcd_q       <= bcd_d;
    end
  end

  assign busy    = busy_q;
  assign grant   = grant_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign bcd_out = bcd_q;

endmodule
